updn_counter_mode: RTL and testbench

//   Parametrised up/down counter with synchronous active-low load, programmable

---
 rtl/counter_pkg.sv | 13 +
 rtl/cnt_next_calc.sv | 67 ++++++
 rtl/updn_counter_mode.sv | 127 ++++++++++++
 tb/tb_updn_counter_mode.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Definitions shared by every counter variant and its checkers.
//   cnt_mode_e selects what happens when a count update runs past a range
//   bound: CNT_WRAP folds the result back into the range, CNT_SAT pins it to
//   the bound that was crossed.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP,
    CNT_SAT
  } cnt_mode_e;

endpackage

// File: rtl/cnt_next_calc.sv
// cnt_next_calc
//   Combinational next-offset calculator for a bounded up/down counter.
//   The counter is handled in offset form (offset 0 = lower bound), so the
//   legal offsets are 0..SPAN and the range holds SPAN+1 values.
// Ports
//   off       in   WIDTH    current offset from the lower bound
//   step      in   STEP_W   amount to add or subtract
//   dir       in   1        1 = up, 0 = down
//   mode      in   1        wrap or saturate behaviour at the bounds
//   next_off  out  WIDTH    offset after the update
//   ovf       out  1        the update went past the upper bound
//   unf       out  1        the update went past the lower bound
module cnt_next_calc
  import counter_pkg::*;
#(
  parameter int     WIDTH  = 16,
  parameter int     STEP_W = 4,
  parameter longint SPAN   = 65535
) (
  input  logic [WIDTH-1:0]  off,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  cnt_mode_e         mode,
  output logic [WIDTH-1:0]  next_off,
  output logic              ovf,
  output logic              unf
);

  // Two spare bits above the wider operand, so off+step and off+RANGE
  // can never overflow the internal arithmetic.
  localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;
  localparam logic [CW-1:0] SPAN_X  = CW'(SPAN);
  localparam logic [CW-1:0] RANGE_X = CW'(SPAN + 1);

  logic [CW-1:0] off_x;
  logic [CW-1:0] step_x;
  logic [CW-1:0] step_m;
  logic [CW-1:0] up_sum;
  logic [CW-1:0] up_wrap;
  logic [CW-1:0] dn_wrap;
  logic [CW-1:0] next_x;

  // The step is first reduced modulo the range, so a step of RANGE or more
  // still lands on the correct wrapped value with a single correction.
  // The crossing tests use the unreduced step, because any step that large
  // always crosses a bound.
  always_comb begin
    off_x   = CW'(off);
    step_x  = CW'(step);
    step_m  = step_x % RANGE_X;
    up_sum  = off_x + step_m;
    up_wrap = (up_sum >= RANGE_X) ? (up_sum - RANGE_X) : up_sum;
    dn_wrap = (off_x >= step_m) ? (off_x - step_m) : (off_x + RANGE_X - step_m);
    ovf     = 1'b0;
    unf     = 1'b0;
    next_x  = off_x;
    if (dir) begin
      ovf    = (off_x + step_x) > SPAN_X;
      next_x = (mode == CNT_SAT && ovf) ? SPAN_X : up_wrap;
    end else begin
      unf    = step_x > off_x;
      next_x = (mode == CNT_SAT && unf) ? '0 : dn_wrap;
    end
    next_off = WIDTH'(next_x);
  end

endmodule

// File: rtl/updn_counter_mode.sv
// updn_counter_mode
//   Bounded up/down counter with active-low synchronous load, programmable
//   step, wrap or saturate behaviour, terminal-count decode, one-cycle
//   overflow/underflow pulses and sticky overflow/underflow flags.
// Ports
//   clk        in   1       rising-edge clock
//   rst_       in   1       asynchronous reset, active low
//   data_in    in   WIDTH   load value (clamped into [MIN_VAL..MAX_VAL])
//   ld_cnt     in   1       synchronous load, active low, beats counting
//   updn_cnt   in   1       1 = count up, 0 = count down
//   count_enb  in   1       count enable
//   step       in   STEP_W  amount per enabled cycle
//   clr_flags  in   1       clears the sticky flags (a new crossing wins)
//   data_out   out  WIDTH   registered count
//   tc_up      out  1       count is at MAX_VAL
//   tc_dn      out  1       count is at MIN_VAL
//   ovf_p      out  1       last update crossed MAX_VAL
//   unf_p      out  1       last update crossed MIN_VAL
//   ovf_stk    out  1       sticky overflow
//   unf_stk    out  1       sticky underflow
module updn_counter_mode
  import counter_pkg::*;
#(
  parameter int        WIDTH   = 16,
  parameter int        STEP_W  = 4,
  parameter longint    MIN_VAL = 0,
  parameter longint    MAX_VAL = (longint'(1) << WIDTH) - 1,
  parameter cnt_mode_e MODE    = CNT_WRAP
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ld_cnt,
  input  logic              updn_cnt,
  input  logic              count_enb,
  input  logic [STEP_W-1:0] step,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              ovf_p,
  output logic              unf_p,
  output logic              ovf_stk,
  output logic              unf_stk
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam longint           SPAN  = MAX_VAL - MIN_VAL;

  // A range that is empty or does not fit in WIDTH bits cannot be built.
  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (longint'(1) << WIDTH) - 1))
  begin : g_bad_range
    $fatal(1, "updn_counter_mode: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  logic [WIDTH-1:0] off;
  logic [WIDTH-1:0] next_off;
  logic [WIDTH-1:0] load_val;
  logic             ovf;
  logic             unf;
  logic             cnt_cycle;

  assign off       = data_out - MIN_W;
  assign cnt_cycle = ld_cnt && count_enb;

  // Loads are clamped so the register never leaves the legal range.
  assign load_val = (data_in < MIN_W) ? MIN_W :
                    (data_in > MAX_W) ? MAX_W : data_in;

  assign tc_up = (data_out == MAX_W);
  assign tc_dn = (data_out == MIN_W);

  cnt_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .SPAN   (SPAN)
  ) u_next (
    .off      (off),
    .step     (step),
    .dir      (updn_cnt),
    .mode     (MODE),
    .next_off (next_off),
    .ovf      (ovf),
    .unf      (unf)
  );

  // Count register and crossing pulses. Pulses default low every cycle and
  // are raised only on an enabled count that crosses a bound.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_out <= MIN_W;
      ovf_p    <= 1'b0;
      unf_p    <= 1'b0;
    end else begin
      ovf_p <= 1'b0;
      unf_p <= 1'b0;
      if (!ld_cnt) begin
        data_out <= load_val;
      end else if (count_enb) begin
        data_out <= MIN_W + next_off;
        ovf_p    <= ovf;
        unf_p    <= unf;
      end
    end
  end

  // Sticky flags: a crossing on this edge outranks a clear on the same edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ovf_stk <= 1'b0;
      unf_stk <= 1'b0;
    end else begin
      if (cnt_cycle && ovf) begin
        ovf_stk <= 1'b1;
      end else if (clr_flags) begin
        ovf_stk <= 1'b0;
      end
      if (cnt_cycle && unf) begin
        unf_stk <= 1'b1;
      end else if (clr_flags) begin
        unf_stk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_updn_counter_mode.sv
// tb_updn_counter_mode
//   Drives a wrapping and a saturating instance (WIDTH=8, STEP_W=4,
//   range 10..200) from shared inputs and compares both against a plain
//   integer model of the counting rules.
module tb_updn_counter_mode;
  import counter_pkg::*;

  localparam int MIN = 10;
  localparam int MAX = 200;
  localparam int RANGE = MAX - MIN + 1;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] data_in = '0;
  logic       ld_cnt = 1'b1;
  logic       updn_cnt = 1'b1;
  logic       count_enb = 1'b0;
  logic [3:0] step = '0;
  logic       clr_flags = 1'b0;

  logic [7:0] dout [2];
  logic       tcu [2];
  logic       tcd [2];
  logic       ovp [2];
  logic       unp [2];
  logic       ovs [2];
  logic       uns [2];

  int  m_cnt [2];
  bit  m_ovf [2];
  bit  m_unf [2];
  bit  m_ovs [2];
  bit  m_uns [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updn_counter_mode #(.WIDTH(8), .STEP_W(4), .MIN_VAL(MIN), .MAX_VAL(MAX), .MODE(CNT_WRAP)) dut_wrap (
    .clk(clk), .rst_(rst_), .data_in(data_in), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt),
    .count_enb(count_enb), .step(step), .clr_flags(clr_flags), .data_out(dout[0]),
    .tc_up(tcu[0]), .tc_dn(tcd[0]), .ovf_p(ovp[0]), .unf_p(unp[0]), .ovf_stk(ovs[0]), .unf_stk(uns[0]));

  updn_counter_mode #(.WIDTH(8), .STEP_W(4), .MIN_VAL(MIN), .MAX_VAL(MAX), .MODE(CNT_SAT)) dut_sat (
    .clk(clk), .rst_(rst_), .data_in(data_in), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt),
    .count_enb(count_enb), .step(step), .clr_flags(clr_flags), .data_out(dout[1]),
    .tc_up(tcu[1]), .tc_dn(tcd[1]), .ovf_p(ovp[1]), .unf_p(unp[1]), .ovf_stk(ovs[1]), .unf_stk(uns[1]));

  // Reference model: the count as a plain integer in [MIN..MAX]. Index 0 wraps, index 1 saturates.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = MIN; m_ovf[k] = 0; m_unf[k] = 0; m_ovs[k] = 0; m_uns[k] = 0;
    end
  endtask

  task automatic model_step(input bit ld, input int din, input bit up, input bit en, input int st, input bit clr);
    for (int k = 0; k < 2; k++) begin
      int v;
      bit o;
      bit u;
      o = 0;
      u = 0;
      v = m_cnt[k];
      if (!ld) begin
        v = (din < MIN) ? MIN : ((din > MAX) ? MAX : din);
      end else if (en) begin
        v = up ? (m_cnt[k] + st) : (m_cnt[k] - st);
        o = up && (v > MAX);
        u = !up && (v < MIN);
        if (k == 1) begin
          if (o) v = MAX;
          if (u) v = MIN;
        end else begin
          v = MIN + ((((v - MIN) % RANGE) + RANGE) % RANGE);
        end
      end
      m_cnt[k] = v;
      m_ovf[k] = o;
      m_unf[k] = u;
      if (o) m_ovs[k] = 1; else if (clr) m_ovs[k] = 0;
      if (u) m_uns[k] = 1; else if (clr) m_uns[k] = 0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and sample 1 ns after the edge.
  task automatic drive(input bit ld, input logic [7:0] din, input bit up, input bit en,
                       input logic [3:0] st, input bit clr);
    ld_cnt = ld; data_in = din; updn_cnt = up; count_enb = en; step = st; clr_flags = clr;
    model_step(ld, int'(din), up, en, int'(st), clr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout[k] !== 8'd10 || ovp[k] !== 1'b0 || unp[k] !== 1'b0 || ovs[k] !== 1'b0 || uns[k] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset[%0d]: data_out=%0d ovf_p=%b unf_p=%b ovf_stk=%b unf_stk=%b, required 10 0 0 0 0",
                 k, dout[k], ovp[k], unp[k], ovs[k], uns[k]);
      end
    end
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_clamp();
    drive(0, 8'd250, 1, 0, 4'd0, 0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout[k] !== 8'd200 || tcu[k] !== 1'b1 || tcd[k] !== 1'b0 || ovp[k] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL load_high[%0d]: data_out=%0d tc_up=%b tc_dn=%b ovf_p=%b, required 200 1 0 0",
                 k, dout[k], tcu[k], tcd[k], ovp[k]);
      end
    end
    drive(0, 8'd3, 1, 0, 4'd0, 0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout[k] !== 8'd10 || tcd[k] !== 1'b1 || tcu[k] !== 1'b0 || unp[k] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL load_low[%0d]: data_out=%0d tc_dn=%b tc_up=%b unf_p=%b, required 10 1 0 0",
                 k, dout[k], tcd[k], tcu[k], unp[k]);
      end
    end
  endtask

  task automatic test_wrap_up();
    drive(0, 8'd198, 1, 0, 4'd5, 0);
    drive(1, 8'd0, 1, 1, 4'd5, 0);
    n_checks++;
    if (dout[0] !== 8'd12 || ovp[0] !== 1'b1 || ovs[0] !== 1'b1 || unp[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wrap_up: data_out=%0d ovf_p=%b ovf_stk=%b unf_p=%b, required 12 1 1 0",
               dout[0], ovp[0], ovs[0], unp[0]);
    end
    drive(1, 8'd0, 1, 0, 4'd5, 0);
    n_checks++;
    if (dout[0] !== 8'd12 || ovp[0] !== 1'b0 || ovs[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrap_up_pulse_end: data_out=%0d ovf_p=%b ovf_stk=%b, required 12 0 1",
               dout[0], ovp[0], ovs[0]);
    end
    drive(1, 8'd0, 1, 0, 4'd0, 1);
    n_checks++;
    if (ovs[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_clear: ovf_stk=%b, required 0", ovs[0]);
    end
  endtask

  task automatic test_wrap_down();
    drive(0, 8'd12, 0, 0, 4'd5, 0);
    drive(1, 8'd0, 0, 1, 4'd5, 0);
    n_checks++;
    if (dout[0] !== 8'd198 || unp[0] !== 1'b1 || uns[0] !== 1'b1 || ovp[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wrap_down: data_out=%0d unf_p=%b unf_stk=%b ovf_p=%b, required 198 1 1 0",
               dout[0], unp[0], uns[0], ovp[0]);
    end
    drive(0, 8'd12, 0, 0, 4'd5, 0);
    drive(1, 8'd0, 0, 1, 4'd5, 1);
    n_checks++;
    if (uns[0] !== 1'b1 || unp[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL set_beats_clear: unf_stk=%b unf_p=%b, required 1 1", uns[0], unp[0]);
    end
    drive(1, 8'd0, 0, 0, 4'd0, 1);
    n_checks++;
    if (uns[0] !== 1'b0 || unp[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unf_clear: unf_stk=%b unf_p=%b, required 0 0", uns[0], unp[0]);
    end
  endtask

  task automatic test_sat();
    drive(0, 8'd195, 1, 0, 4'd7, 0);
    for (int r = 0; r < 2; r++) begin
      drive(1, 8'd0, 1, 1, 4'd7, 0);
      n_checks++;
      if (dout[1] !== 8'd200 || ovp[1] !== 1'b1 || ovs[1] !== 1'b1 || tcu[1] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL sat_up_%0d: data_out=%0d ovf_p=%b ovf_stk=%b tc_up=%b, required 200 1 1 1",
                 r, dout[1], ovp[1], ovs[1], tcu[1]);
      end
    end
    drive(1, 8'd0, 0, 0, 4'd9, 0);
    n_checks++;
    if (dout[1] !== 8'd200 || ovp[1] !== 1'b0 || unp[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sat_hold: data_out=%0d ovf_p=%b unf_p=%b, required 200 0 0", dout[1], ovp[1], unp[1]);
    end
    drive(0, 8'd13, 0, 0, 4'd0, 0);
    drive(1, 8'd0, 0, 1, 4'd6, 0);
    n_checks++;
    if (dout[1] !== 8'd10 || unp[1] !== 1'b1 || dout[0] !== 8'd198) begin
      n_fail++;
      $display("[TB] FAIL sat_down: sat data_out=%0d unf_p=%b wrap data_out=%0d, required 10 1 198",
               dout[1], unp[1], dout[0]);
    end
  endtask

  task automatic test_priority();
    drive(0, 8'd100, 1, 1, 4'd3, 0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout[k] !== 8'd100 || ovp[k] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL load_over_count[%0d]: data_out=%0d ovf_p=%b, required 100 0", k, dout[k], ovp[k]);
      end
    end
    drive(1, 8'd0, 1, 1, 4'd0, 0);
    drive(1, 8'd0, 0, 1, 4'd0, 0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout[k] !== 8'd100 || ovp[k] !== 1'b0 || unp[k] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL step_zero[%0d]: data_out=%0d ovf_p=%b unf_p=%b, required 100 0 0",
                 k, dout[k], ovp[k], unp[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 7) != 0), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dout[k] !== 8'(m_cnt[k]) || ovp[k] !== m_ovf[k] || unp[k] !== m_unf[k] ||
            ovs[k] !== m_ovs[k] || uns[k] !== m_uns[k] ||
            tcu[k] !== (m_cnt[k] == MAX) || tcd[k] !== (m_cnt[k] == MIN)) begin
          n_fail++;
          $display("[TB] FAIL random[%0d] inst %0d: got cnt=%0d ovp=%b unp=%b ovs=%b uns=%b tcu=%b tcd=%b, required cnt=%0d ovp=%b unp=%b ovs=%b uns=%b",
                   i, k, dout[k], ovp[k], unp[k], ovs[k], uns[k], tcu[k], tcd[k],
                   m_cnt[k], m_ovf[k], m_unf[k], m_ovs[k], m_uns[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    drive(0, 8'd198, 1, 0, 4'd0, 0);
    drive(1, 8'd0, 1, 1, 4'd5, 0);
    drive(0, 8'd57, 1, 0, 4'd0, 0);
    ld_cnt = 1'b1; updn_cnt = 1'b1; count_enb = 1'b1; step = 4'd3;
    #2;
    rst_ = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout[k] !== 8'd10 || ovp[k] !== 1'b0 || unp[k] !== 1'b0 || ovs[k] !== 1'b0 ||
          uns[k] !== 1'b0 || tcd[k] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_count[%0d]: data_out=%0d ovf_p=%b unf_p=%b ovf_stk=%b unf_stk=%b tc_dn=%b, required 10 0 0 0 0 1",
                 k, dout[k], ovp[k], unp[k], ovs[k], uns[k], tcd[k]);
      end
    end
    count_enb = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    drive(1, 8'd0, 1, 1, 4'd4, 0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dout[k] !== 8'd14) begin
        n_fail++;
        $display("[TB] FAIL first_count_after_reset[%0d]: data_out=%0d, required 14", k, dout[k]);
      end
    end
  endtask

  initial begin
    $display("[TB] starting updn_counter_mode bench");
    test_reset();
    test_load_clamp();
    test_wrap_up();
    test_wrap_down();
    test_sat();
    test_priority();
    test_random();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
